// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: consumes one dispatched word per data_valid/write_ok
// handshake and turns it into one or more 16-bit writes on an 8080-style
// parallel LCD bus (write only, lcd_rd held high).
//
// Optional feature macro: LCD_BUS_WRITER_FILL_EN
//   defined   -> command 0x2C repeats its data beat graph_size[23:0] times
//   undefined -> 0x2C behaves like every other command (one data beat)
module lcd_bus_writer #(
   parameter int WR_LOW_CYC  = 2,
   parameter int WR_HIGH_CYC = 2
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [31:0] buffer_data,
   input  logic [31:0] buffer_addr,
   input  logic        data_valid,
   input  logic [31:0] graph_size,
   input  logic        refresh,
   input  logic        refresh_rs,
   output logic        write_ok,
   output logic        lcd_csel,
   output logic        lcd_rs,
   output logic        lcd_wr,
   output logic        lcd_rd,
   output logic [15:0] lcd_data_o,
   output logic        lcd_data_oe
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] phase_cnt;
   logic [15:0] data_word;
   logic        cmd_beat;
   logic        lo_done;
   logic        hi_done;
   logic        last_data_beat;
   logic        unused_inputs;

   assign lo_done = (phase_cnt == 16'(WR_LOW_CYC - 1));
   assign hi_done = (phase_cnt == 16'(WR_HIGH_CYC - 1));
   assign lcd_rd  = 1'b1;

`ifdef LCD_BUS_WRITER_FILL_EN
   logic [23:0] fill_cnt;
   logic [23:0] fill_init;
   logic        is_fill_cmd;

   // A fill is the 0x2C command word (offset byte zero, not a raw word).
   // A zero pixel count still produces one data beat.
   assign is_fill_cmd = !refresh && (buffer_data[23:16] == 8'h00) &&
                        (buffer_data[31:24] == 8'h2C);
   assign fill_init   = (is_fill_cmd && (graph_size[23:0] != 24'd0)) ?
                        graph_size[23:0] : 24'd1;
   assign last_data_beat = (fill_cnt <= 24'd1);
   assign unused_inputs  = ^{buffer_addr, graph_size[31:24]};
`else
   assign last_data_beat = 1'b1;
   assign unused_inputs  = ^{buffer_addr, graph_size};
`endif

   // Handshake, beat sequencing and all registered bus outputs.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         data_word   <= '0;
         cmd_beat    <= 1'b0;
         write_ok    <= 1'b1;
         lcd_csel    <= 1'b1;
         lcd_wr      <= 1'b1;
         lcd_rs      <= 1'b1;
         lcd_data_o  <= '0;
         lcd_data_oe <= 1'b0;
`ifdef LCD_BUS_WRITER_FILL_EN
         fill_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (write_ok && data_valid) begin
                  state       <= WR_LO;
                  phase_cnt   <= '0;
                  data_word   <= buffer_data[15:0];
                  write_ok    <= 1'b0;
                  lcd_csel    <= 1'b0;
                  lcd_wr      <= 1'b0;
                  lcd_data_oe <= 1'b1;
`ifdef LCD_BUS_WRITER_FILL_EN
                  fill_cnt    <= fill_init;
`endif
                  if (refresh) begin
                     lcd_rs     <= refresh_rs;
                     lcd_data_o <= buffer_data[15:0];
                     cmd_beat   <= 1'b0;
                  end else if (buffer_data[23:16] != 8'h00) begin
                     lcd_rs     <= 1'b1;
                     lcd_data_o <= buffer_data[15:0];
                     cmd_beat   <= 1'b0;
                  end else begin
                     lcd_rs     <= 1'b0;
                     lcd_data_o <= {8'h00, buffer_data[31:24]};
                     cmd_beat   <= 1'b1;
                  end
               end
            end

            WR_LO: begin
               if (lo_done) begin
                  state     <= WR_HI;
                  phase_cnt <= '0;
                  lcd_wr    <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt + 16'd1;
               end
            end

            WR_HI: begin
               if (hi_done) begin
                  phase_cnt <= '0;
                  if (cmd_beat) begin
                     cmd_beat   <= 1'b0;
                     state      <= WR_LO;
                     lcd_wr     <= 1'b0;
                     lcd_rs     <= 1'b1;
                     lcd_data_o <= data_word;
                  end else begin
`ifdef LCD_BUS_WRITER_FILL_EN
                     if (fill_cnt != 24'd0) begin
                        fill_cnt <= fill_cnt - 24'd1;
                     end
`endif
                     if (!last_data_beat) begin
                        state  <= WR_LO;
                        lcd_wr <= 1'b0;
                     end else begin
                        state       <= IDLE;
                        write_ok    <= 1'b1;
                        lcd_csel    <= 1'b1;
                        lcd_data_oe <= 1'b0;
                     end
                  end
               end else begin
                  phase_cnt <= phase_cnt + 16'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: directed self-checking bench for lcd_bus_writer with
// WR_LOW_CYC = WR_HIGH_CYC = 2. Expected bus activity is rebuilt per cycle
// from a hand-written beat list for each scenario.
module tb_lcd_bus_writer;

   localparam int LOW = 2;
   localparam int HIGH = 2;
   localparam int B = LOW + HIGH;

`ifdef LCD_BUS_WRITER_FILL_EN
   localparam int FILL3_BEATS = 4;
`else
   localparam int FILL3_BEATS = 2;
`endif

   logic        pclk;
   logic        rst_n;
   logic [31:0] buffer_data;
   logic [31:0] buffer_addr;
   logic        data_valid;
   logic [31:0] graph_size;
   logic        refresh;
   logic        refresh_rs;
   logic        write_ok;
   logic        lcd_csel;
   logic        lcd_rs;
   logic        lcd_wr;
   logic        lcd_rd;
   logic [15:0] lcd_data_o;
   logic        lcd_data_oe;

   int checkCount = 0;
   int errorCount = 0;

   lcd_bus_writer #(
      .WR_LOW_CYC (LOW),
      .WR_HIGH_CYC(HIGH)
   ) dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .buffer_data(buffer_data),
      .buffer_addr(buffer_addr),
      .data_valid (data_valid),
      .graph_size (graph_size),
      .refresh    (refresh),
      .refresh_rs (refresh_rs),
      .write_ok   (write_ok),
      .lcd_csel   (lcd_csel),
      .lcd_rs     (lcd_rs),
      .lcd_wr     (lcd_wr),
      .lcd_rd     (lcd_rd),
      .lcd_data_o (lcd_data_o),
      .lcd_data_oe(lcd_data_oe)
   );

   // Free-running clock, 10 time units per period.
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Count one comparison and report it when the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   // Wait, with a bound, until the writer reports idle.
   task automatic waitReady(input string name);
      int waitCnt;
      waitCnt = 0;
      while (write_ok !== 1'b1 && waitCnt < 200) begin
         @(negedge pclk);
         waitCnt++;
      end
      checkOutput({name, " ready"}, write_ok, 1'b1);
   endtask

   // Present one word, then check every cycle of the resulting transaction
   // plus two idle cycles. Beat 0 uses firstRs/firstData, later beats are
   // data beats carrying restData.
   task automatic applyStimulus(input string name, input logic [31:0] word,
                                input logic rawWord, input logic rawRs,
                                input logic [31:0] gsize, input int nBeats,
                                input logic firstRs, input logic [15:0] firstData,
                                input logic [15:0] restData, input bit pulseBusy);
      int beat;
      int ph;
      logic [15:0] expData;
      logic expRs;
      @(negedge pclk);
      waitReady(name);
      buffer_data = word;
      buffer_addr = 32'hFFFF_0000;
      refresh     = rawWord;
      refresh_rs  = rawRs;
      graph_size  = gsize;
      data_valid  = 1'b1;
      @(posedge pclk);
      for (int c = 1; c <= nBeats * B + 2; c++) begin
         @(negedge pclk);
         if (c == 1) begin
            data_valid  = 1'b0;
            buffer_data = 32'h5A5A_A5A5;
            buffer_addr = 32'h1234_5678;
            refresh     = 1'b0;
            graph_size  = 32'd7;
         end
         if (pulseBusy && c == 2) begin
            data_valid  = 1'b1;
            buffer_data = 32'h3600_0000;
         end
         if (pulseBusy && c == 3) begin
            data_valid = 1'b0;
         end
         if (c <= nBeats * B) begin
            beat    = (c - 1) / B;
            ph      = (c - 1) % B;
            expRs   = (beat == 0) ? firstRs : 1'b1;
            expData = (beat == 0) ? firstData : restData;
            checkOutput($sformatf("%s c%0d write_ok", name, c), write_ok, 1'b0);
            checkOutput($sformatf("%s c%0d csel", name, c), lcd_csel, 1'b0);
            checkOutput($sformatf("%s c%0d oe", name, c), lcd_data_oe, 1'b1);
            checkOutput($sformatf("%s c%0d wr", name, c), lcd_wr, (ph >= LOW) ? 1'b1 : 1'b0);
            checkOutput($sformatf("%s c%0d rs", name, c), lcd_rs, expRs);
            checkOutput($sformatf("%s c%0d data", name, c), lcd_data_o, expData);
         end else begin
            expData = (nBeats == 1) ? firstData : restData;
            checkOutput($sformatf("%s c%0d write_ok", name, c), write_ok, 1'b1);
            checkOutput($sformatf("%s c%0d csel", name, c), lcd_csel, 1'b1);
            checkOutput($sformatf("%s c%0d oe", name, c), lcd_data_oe, 1'b0);
            checkOutput($sformatf("%s c%0d wr", name, c), lcd_wr, 1'b1);
            checkOutput($sformatf("%s c%0d data", name, c), lcd_data_o, expData);
         end
      end
   endtask

   // Directed scenario sequence.
   initial begin
      rst_n       = 1'b0;
      buffer_data = '0;
      buffer_addr = '0;
      data_valid  = 1'b0;
      graph_size  = '0;
      refresh     = 1'b0;
      refresh_rs  = 1'b0;

      repeat (2) @(negedge pclk);
      checkOutput("reset write_ok", write_ok, 1'b1);
      checkOutput("reset csel", lcd_csel, 1'b1);
      checkOutput("reset wr", lcd_wr, 1'b1);
      checkOutput("reset rd", lcd_rd, 1'b1);
      checkOutput("reset rs", lcd_rs, 1'b1);
      checkOutput("reset data", lcd_data_o, 16'h0000);
      checkOutput("reset oe", lcd_data_oe, 1'b0);
      rst_n = 1'b1;

      $display("[TB] raw word with busy pulse");
      applyStimulus("raw", 32'h0000_0011, 1'b1, 1'b0, 32'd0, 1, 1'b0, 16'h0011, 16'h0011, 1'b1);

      $display("[TB] command word");
      applyStimulus("cmd", 32'h2A00_0028, 1'b0, 1'b0, 32'd0, 2, 1'b0, 16'h002A, 16'h0028, 1'b0);

      $display("[TB] parameter word");
      applyStimulus("param", 32'h2A02_01B7, 1'b0, 1'b0, 32'd0, 1, 1'b1, 16'h01B7, 16'h01B7, 1'b0);

      $display("[TB] fill with graph_size 3");
      applyStimulus("fill3", 32'h2C00_FF45, 1'b0, 1'b0, 32'd3, FILL3_BEATS, 1'b0, 16'h002C, 16'hFF45, 1'b0);

      $display("[TB] fill with graph_size 0");
      applyStimulus("fill0", 32'h2C00_FF45, 1'b0, 1'b0, 32'd0, 2, 1'b0, 16'h002C, 16'hFF45, 1'b0);

      $display("[TB] reset during a long fill");
      @(negedge pclk);
      waitReady("rstfill");
      buffer_data = 32'h2C00_FF45;
      refresh     = 1'b0;
      graph_size  = 32'd100;
      data_valid  = 1'b1;
      @(posedge pclk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge pclk);
         if (c == 1) data_valid = 1'b0;
      end
      checkOutput("rstfill pre csel", lcd_csel, 1'b0);
      checkOutput("rstfill pre data", lcd_data_o, 16'hFF45);
      checkOutput("rstfill pre write_ok", write_ok, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("rstfill csel", lcd_csel, 1'b1);
      checkOutput("rstfill wr", lcd_wr, 1'b1);
      checkOutput("rstfill oe", lcd_data_oe, 1'b0);
      checkOutput("rstfill write_ok", write_ok, 1'b1);
      checkOutput("rstfill data", lcd_data_o, 16'h0000);
      @(negedge pclk);
      rst_n = 1'b1;

      applyStimulus("post", 32'h2A02_01B7, 1'b0, 1'b0, 32'd0, 1, 1'b1, 16'h01B7, 16'h01B7, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      errorCount++;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
